seg_scan_driver: RTL
====================

SEG_SCAN_DRIVER -- requirements
Module: seg_scan_driver

Interface
REQ-001 SHALL have parameter NUM_DIGITS, default 6: number of multiplexed digits, legal range 2..8.
REQ-002 SHALL have parameter SUB_DIV, default 1563: clock cycles per brightness sub-slot, minimum 1.
REQ-003 SHALL have parameter BRIGHT_W, default 4: brightness width; each digit slot lasts SUB_DIV*2^BRIGHT_W cycles.
REQ-004 SHALL have parameter BLINK_FRAMES, default 64: frames per blink half-period, minimum 1.
REQ-005 SHALL have port clk, input, 1 bit: single clock; all logic on its rising edge.
REQ-006 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 SHALL have port digits_i, input, 4*NUM_DIGITS bits: hex code per digit; nibble k drives digit k.
REQ-008 SHALL have port dp_i, input, NUM_DIGITS bits: decimal point per digit, 1 = lit.
REQ-009 SHALL have port blank_i, input, NUM_DIGITS bits: 1 = digit dark.
REQ-010 SHALL have port load_i, input, 1 bit: 1-cycle strobe capturing digits_i, dp_i, blank_i and blink_mask_i.
REQ-011 SHALL have port bright_i, input, BRIGHT_W bits: brightness level, sampled every cycle.
REQ-012 SHALL have port blink_mask_i, input, NUM_DIGITS bits: 1 = digit blinks (present only with SEG_BLINK_EN).
REQ-013 SHALL have port sel_o, output, NUM_DIGITS bits: digit enables, active-low, at most one bit low.
REQ-014 SHALL have port seg_o, output, 8 bits: segments, active-low; bit7 = dp, bits6..0 = g..a.
REQ-015 SHALL have port frame_o, output, 1 bit: 1-cycle pulse at each frame start.

Function
REQ-016 SHALL hold a slot counter 0..SUB_DIV*2^BRIGHT_W-1 and a digit index 0..NUM_DIGITS-1; at the slot terminal count the index increments, wrapping NUM_DIGITS-1 -> 0.
REQ-017 SHALL register sel_o and seg_o, updating both in the cycle after the counter/index change so that they stay aligned.
REQ-018 SHALL decode the full hex range 0..F to the standard 7-segment glyphs (0 = 8'hC0 with dp off, 8 = 8'h80).
REQ-019 SHALL drive the current digit's sel bit low only during sub-slots 0..bright_i of its slot; bright_i = all-ones means always on, 0 means 1/2^BRIGHT_W duty.
REQ-020 SHALL drive sel_o all-ones and seg_o 8'hFF while the current digit is blanked or in its PWM off phase.
REQ-021 SHALL capture inputs on load_i into a pending register; with multiple loads in one frame, the last load wins.
REQ-022 SHALL copy pending to the active register only at a frame boundary (index wrap to 0), so that no frame mixes old and new data.
REQ-023 SHALL apply a load_i that coincides with the boundary cycle at that same boundary.
REQ-024 SHALL pulse frame_o in the cycle in which the active register updates, whether or not a load occurred.

Reset
REQ-025 SHALL on rst clear the counters, index, blink phase and dp bits, set digit codes to 0 and set blank to all-ones; sel_o SHALL be all-ones, seg_o 8'hFF and frame_o 0.
REQ-026 SHALL let rst override load_i in the same cycle; scanning SHALL restart at digit 0 on the first cycle after release.

Configuration
REQ-027 SHALL, with SEG_BLINK_EN defined, count frames and toggle a blink phase every BLINK_FRAMES frames; digits with the active blink_mask bit set SHALL be dark in the off phase.
REQ-028 SHALL, without SEG_BLINK_EN, omit blink_mask_i, the frame counter and the blink phase, with no digit ever blinking.

Structure
REQ-029 SHALL keep the 7-segment glyph constants, the all-off constants and the hex-code typedef in shared package seg_pkg.
REQ-030 SHALL use one combinational sub-module seg_hex_decoder (4-bit code plus dp -> 8-bit active-low pattern).

Verification (NUM_DIGITS=4, SUB_DIV=2, BRIGHT_W=2, BLINK_FRAMES=2: slot 8 cycles, frame 32 cycles)
REQ-031 SHALL cover: reset released -> sel_o=4'b1111 and seg_o=8'hFF until the first load; frame_o pulses every 32 cycles.
REQ-032 SHALL cover: load digits=16'h4321, blank=0, bright=3 -> after the next boundary, sel_o cycles 1110/1101/1011/0111, each for 8 cycles, with seg_o 8'hF9/8'hA4/8'hB0/8'h99.
REQ-033 SHALL cover: bright=0 -> each digit is low for 2 of 8 cycles; bright=1 -> 4 of 8 cycles.
REQ-034 SHALL cover: load 16'h1111 mid-frame, then 16'h2222 before the boundary -> the old value holds to the end of the frame, then only 2 (8'hA4) is shown.
REQ-035 SHALL cover: load coincident with the boundary cycle -> the new data is shown in that frame; rst asserted mid-slot -> all-off next cycle, then restart at digit 0.
REQ-036 SHALL cover (SEG_BLINK_EN): blink_mask=4'b0001 -> digit 0 is dark in alternate 2-frame windows while the other digits are unaffected; dp_i[2]=1 -> digit 2 has bit7 low.

Source files
------------

// File: rtl/seg_pkg.sv
// seg_pkg: shared hex-code type, active-low 7-segment glyph constants and
// the all-off patterns used by the multiplexed display driver.
package seg_pkg;

  // One display digit is addressed by a 4-bit hex code.
  typedef logic [3:0] hex_code_t;

  // Active-low glyphs, bit order g..a (bit6..bit0).
  localparam logic [6:0] GLYPH_0 = 7'h40;
  localparam logic [6:0] GLYPH_1 = 7'h79;
  localparam logic [6:0] GLYPH_2 = 7'h24;
  localparam logic [6:0] GLYPH_3 = 7'h30;
  localparam logic [6:0] GLYPH_4 = 7'h19;
  localparam logic [6:0] GLYPH_5 = 7'h12;
  localparam logic [6:0] GLYPH_6 = 7'h02;
  localparam logic [6:0] GLYPH_7 = 7'h78;
  localparam logic [6:0] GLYPH_8 = 7'h00;
  localparam logic [6:0] GLYPH_9 = 7'h10;
  localparam logic [6:0] GLYPH_A = 7'h08;
  localparam logic [6:0] GLYPH_B = 7'h03;
  localparam logic [6:0] GLYPH_C = 7'h46;
  localparam logic [6:0] GLYPH_D = 7'h21;
  localparam logic [6:0] GLYPH_E = 7'h06;
  localparam logic [6:0] GLYPH_F = 7'h0E;

  // Segment bus with every segment and the decimal point dark.
  localparam logic [7:0] SEG_ALL_OFF = 8'hFF;

  // A digit enable that is deasserted (enables are active-low).
  localparam logic SEL_OFF = 1'b1;

  // Merge a glyph with a decimal point request into the 8-bit bus.
  function automatic logic [7:0] seg_with_dp(input logic [6:0] glyph, input logic dp);
    return {~dp, glyph};
  endfunction

endpackage

// File: rtl/seg_hex_decoder.sv
// seg_hex_decoder: purely combinational hex code + decimal point to an
// active-low 8-bit segment pattern (bit7 = dp, bits6..0 = g..a).
module seg_hex_decoder
  import seg_pkg::*;
(
  input  hex_code_t  code,
  input  logic       dp,
  output logic [7:0] pattern
);

  logic [6:0] glyph;

  // Look up the glyph for the full 0..F range.
  always_comb begin
    glyph = GLYPH_8;
    unique case (code)
      4'h0: glyph = GLYPH_0;
      4'h1: glyph = GLYPH_1;
      4'h2: glyph = GLYPH_2;
      4'h3: glyph = GLYPH_3;
      4'h4: glyph = GLYPH_4;
      4'h5: glyph = GLYPH_5;
      4'h6: glyph = GLYPH_6;
      4'h7: glyph = GLYPH_7;
      4'h8: glyph = GLYPH_8;
      4'h9: glyph = GLYPH_9;
      4'hA: glyph = GLYPH_A;
      4'hB: glyph = GLYPH_B;
      4'hC: glyph = GLYPH_C;
      4'hD: glyph = GLYPH_D;
      4'hE: glyph = GLYPH_E;
      4'hF: glyph = GLYPH_F;
      default: glyph = GLYPH_8;
    endcase
  end

  assign pattern = seg_with_dp(glyph, dp);

endmodule

// File: rtl/seg_scan_driver.sv
// seg_scan_driver: time-multiplexed 7-segment display driver with PWM
// brightness and frame-synchronous double-buffered display data.
// Optional feature: define SEG_BLINK_EN to add blink_mask_i and a
// frame-counted blink phase.
module seg_scan_driver
  import seg_pkg::*;
#(
  parameter int NUM_DIGITS   = 6,
  parameter int SUB_DIV      = 1563,
  parameter int BRIGHT_W     = 4,
  parameter int BLINK_FRAMES = 64
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] digits_i,
  input  logic [NUM_DIGITS-1:0]   dp_i,
  input  logic [NUM_DIGITS-1:0]   blank_i,
  input  logic                    load_i,
  input  logic [BRIGHT_W-1:0]     bright_i,
`ifdef SEG_BLINK_EN
  input  logic [NUM_DIGITS-1:0]   blink_mask_i,
`endif
  output logic [NUM_DIGITS-1:0]   sel_o,
  output logic [7:0]              seg_o,
  output logic                    frame_o
);

  // The slot counter is split into a sub-slot prescaler and a sub-slot
  // index so that SUB_DIV = 1 needs no zero-width counter.
  localparam int DIV_W = (SUB_DIV > 1) ? $clog2(SUB_DIV) : 1;
  localparam int IDX_W = $clog2(NUM_DIGITS);
  localparam logic [DIV_W-1:0]    DIV_LAST = DIV_W'(SUB_DIV - 1);
  localparam logic [IDX_W-1:0]    IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [BRIGHT_W-1:0] SUB_LAST = {BRIGHT_W{1'b1}};

  logic [DIV_W-1:0]    div_cnt;
  logic [BRIGHT_W-1:0] sub_slot;
  logic [IDX_W-1:0]    digit_idx;
  logic                div_tc;
  logic                slot_tc;
  logic                frame_tc;

  logic [4*NUM_DIGITS-1:0] pend_digits;
  logic [NUM_DIGITS-1:0]   pend_dp;
  logic [NUM_DIGITS-1:0]   pend_blank;
  logic [4*NUM_DIGITS-1:0] act_digits;
  logic [NUM_DIGITS-1:0]   act_dp;
  logic [NUM_DIGITS-1:0]   act_blank;

  hex_code_t             cur_code;
  logic                  cur_dp;
  logic                  cur_blank;
  logic                  blink_dark;
  logic                  lit;
  logic [7:0]            glyph;
  logic [NUM_DIGITS-1:0] sel_next;

  assign div_tc   = (div_cnt == DIV_LAST);
  assign slot_tc  = div_tc && (sub_slot == SUB_LAST);
  assign frame_tc = slot_tc && (digit_idx == IDX_LAST);

  // Scan counters: prescaler, sub-slot within the digit slot, digit index.
  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt   <= '0;
      sub_slot  <= '0;
      digit_idx <= '0;
    end else begin
      div_cnt <= div_tc ? '0 : div_cnt + 1'b1;
      if (div_tc) begin
        sub_slot <= sub_slot + 1'b1;
      end
      if (slot_tc) begin
        digit_idx <= (digit_idx == IDX_LAST) ? '0 : digit_idx + 1'b1;
      end
    end
  end

  // Double buffer: loads land in pending, the active copy changes only at
  // the frame wrap so a frame never shows a mixture of old and new data.
  // A load in the wrap cycle itself bypasses pending straight into active.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_digits <= '0;
      pend_dp     <= '0;
      pend_blank  <= '1;
      act_digits  <= '0;
      act_dp      <= '0;
      act_blank   <= '1;
    end else begin
      if (load_i) begin
        pend_digits <= digits_i;
        pend_dp     <= dp_i;
        pend_blank  <= blank_i;
      end
      if (frame_tc) begin
        act_digits <= load_i ? digits_i : pend_digits;
        act_dp     <= load_i ? dp_i     : pend_dp;
        act_blank  <= load_i ? blank_i  : pend_blank;
      end
    end
  end

`ifdef SEG_BLINK_EN
  localparam int BF_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [BF_W-1:0] BF_LAST = BF_W'(BLINK_FRAMES - 1);

  logic [BF_W-1:0]       frame_cnt;
  logic                  blink_off;
  logic [NUM_DIGITS-1:0] pend_mask;
  logic [NUM_DIGITS-1:0] act_mask;
  logic                  cur_blink;

  // Count completed frames and flip the blink phase every BLINK_FRAMES.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_off <= 1'b0;
    end else if (frame_tc) begin
      if (frame_cnt == BF_LAST) begin
        frame_cnt <= '0;
        blink_off <= ~blink_off;
      end else begin
        frame_cnt <= frame_cnt + 1'b1;
      end
    end
  end

  // The blink mask is double-buffered exactly like the display data.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_mask <= '0;
      act_mask  <= '0;
    end else begin
      if (load_i) begin
        pend_mask <= blink_mask_i;
      end
      if (frame_tc) begin
        act_mask <= load_i ? blink_mask_i : pend_mask;
      end
    end
  end

  // Pick the blink mask bit of the digit currently being scanned.
  always_comb begin
    cur_blink = 1'b0;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_blink = act_mask[k];
      end
    end
  end

  assign blink_dark = blink_off && cur_blink;
`else
  assign blink_dark = 1'b0;
`endif

  // Select the active data belonging to the digit currently being scanned.
  always_comb begin
    cur_code  = '0;
    cur_dp    = 1'b0;
    cur_blank = 1'b1;
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (digit_idx == IDX_W'(k)) begin
        cur_code  = act_digits[4*k +: 4];
        cur_dp    = act_dp[k];
        cur_blank = act_blank[k];
      end
    end
  end

  seg_hex_decoder u_decoder (
    .code    (cur_code),
    .dp      (cur_dp),
    .pattern (glyph)
  );

  // The digit is lit in sub-slots 0..bright_i unless blanked or blinking off.
  assign lit = (sub_slot <= bright_i) && !cur_blank && !blink_dark;

  // Build the one-cold digit enable for the current index.
  always_comb begin
    sel_next = {NUM_DIGITS{SEL_OFF}};
    for (int k = 0; k < NUM_DIGITS; k++) begin
      if (lit && (digit_idx == IDX_W'(k))) begin
        sel_next[k] = ~SEL_OFF;
      end
    end
  end

  // Register the pins together so enables and segments never skew.
  always_ff @(posedge clk) begin
    if (rst) begin
      sel_o   <= {NUM_DIGITS{SEL_OFF}};
      seg_o   <= SEG_ALL_OFF;
      frame_o <= 1'b0;
    end else begin
      sel_o   <= sel_next;
      seg_o   <= lit ? glyph : SEG_ALL_OFF;
      frame_o <= frame_tc;
    end
  end

endmodule
